// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment MMIO peripheral: register word
// addresses, CTRL bit positions, STATUS field positions, the CTRL register
// layout and a byte-strobe merge helper for the 16-bit registers.
// -----------------------------------------------------------------------------
package seg7_pkg;

   // Register word addresses (i_addr).
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_DIV    = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   // CTRL bit indices.
   localparam int CTRL_EN    = 0;
   localparam int CTRL_BLINK = 1;

   // STATUS field positions; the blink counter starts at STATUS_BCNT_LSB.
   localparam int STATUS_PHASE    = 0;
   localparam int STATUS_SCAN     = 1;
   localparam int STATUS_BCNT_LSB = 8;

   typedef struct packed {
      logic blink;
      logic en;
   } ctrl_t;

   // Apply the two low byte strobes of a write to a 16-bit register.
   function automatic logic [15:0] merge16(input logic [15:0] old_val,
                                           input logic [15:0] wdata,
                                           input logic [1:0]  wstrb);
      logic [15:0] res;
      res = old_val;
      if (wstrb[0]) res[7:0]  = wdata[7:0];
      if (wstrb[1]) res[15:8] = wdata[15:8];
      return res;
   endfunction

endpackage

// File: rtl/seg7_scan_div.sv
// -----------------------------------------------------------------------------
// seg7_scan_div
// Programmable scan-clock divider. A counter runs on i_clk; when it equals
// i_div it restarts from zero and the scan clock toggles, so the half-period
// is i_div+1 cycles. i_clr restarts the count and suppresses a toggle that
// would otherwise happen in the same cycle.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_div       terminal count
//   i_clr       restart the count this edge (takes priority over a toggle)
//   o_scan_clk  divided scan clock, registered
//   o_rise      high in the cycle whose edge takes o_scan_clk from 0 to 1
// -----------------------------------------------------------------------------
module seg7_scan_div (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_div,
   input  logic        i_clr,
   output logic        o_scan_clk,
   output logic        o_rise
);

   logic [15:0] cnt_q;
   logic        terminal;

   // Compare against the live terminal count; a clear always restarts from 0,
   // so a DIV lowered below the current count can never run through 65535.
   assign terminal = (cnt_q == i_div) && !i_clr;
   assign o_rise   = terminal && !o_scan_clk;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q      <= '0;
         o_scan_clk <= 1'b0;
      end else if (i_clr) begin
         cnt_q      <= '0;
      end else if (terminal) begin
         cnt_q      <= '0;
         o_scan_clk <= ~o_scan_clk;
      end else begin
         cnt_q      <= cnt_q + 16'd1;
      end
   end

endmodule

// File: rtl/seg7_mmio.sv
// -----------------------------------------------------------------------------
// seg7_mmio
// Register-bus peripheral in front of the 7-segment scan driver. Holds the
// 16-bit display value, generates the scan clock and the blank/blink control.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_req, i_we    one access per cycle i_req is high; i_we selects write
//   i_addr         0 DATA, 1 CTRL, 2 DIV, 3 STATUS (read-only)
//   i_wdata/wstrb  write data and byte enables
//   o_ack          one cycle after each sampled request
//   o_rdata        read data while o_ack is high, otherwise 0
//   o_data         display value to the scan driver
//   o_scan_clk     divided scan clock to the scan driver
//   o_blank        forces all digit selects inactive when high
// -----------------------------------------------------------------------------
module seg7_mmio
   import seg7_pkg::*;
#(
   parameter logic [15:0] DIV_DEFAULT = 16'd24999,
   parameter int          BLINK_W     = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   output logic        o_ack,
   output logic [31:0] o_rdata,
   output logic [15:0] o_data,
   output logic        o_scan_clk,
   output logic        o_blank
);

   logic [15:0]        data_q;
   logic [15:0]        div_q;
   ctrl_t              ctrl_q;
   logic [BLINK_W-1:0] bcnt_q;
   logic               blank_q;

   logic               wr_en;
   logic               div_clr;
   logic               scan_clk;
   logic               scan_rise;
   logic               phase;
   logic [31:0]        status_word;
   logic [31:0]        rd_mux;
   logic               unused_bits;

   assign wr_en   = i_req && i_we;
   // Any write touching a DIV byte restarts the divider in the same edge.
   assign div_clr = wr_en && (i_addr == ADDR_DIV) && (|i_wstrb[1:0]);
   assign phase   = bcnt_q[BLINK_W-1];

   // Upper write bytes map to nothing in this block.
   assign unused_bits = ^{i_wdata[31:16], i_wstrb[3:2]};

   seg7_scan_div u_scan_div (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_div      (div_q),
      .i_clr      (div_clr),
      .o_scan_clk (scan_clk),
      .o_rise     (scan_rise)
   );

   // NOTE: every combinational output gets a default before any branch, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      status_word                                  = '0;
      status_word[STATUS_PHASE]                    = phase;
      status_word[STATUS_SCAN]                     = scan_clk;
      status_word[STATUS_BCNT_LSB +: BLINK_W]      = bcnt_q;
   end

   always_comb begin
      rd_mux = '0;
      case (i_addr)
         ADDR_DATA:   rd_mux[15:0] = data_q;
         ADDR_CTRL:   rd_mux[1:0]  = {ctrl_q.blink, ctrl_q.en};
         ADDR_DIV:    rd_mux[15:0] = div_q;
         ADDR_STATUS: rd_mux       = status_word;
         default:     rd_mux       = '0;
      endcase
   end

   // Register file; STATUS writes are acknowledged but change nothing.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q <= '0;
         div_q  <= DIV_DEFAULT;
         ctrl_q <= '{blink: 1'b0, en: 1'b1};
      end else if (wr_en) begin
         case (i_addr)
            ADDR_DATA: data_q <= merge16(data_q, i_wdata[15:0], i_wstrb[1:0]);
            ADDR_DIV:  div_q  <= merge16(div_q, i_wdata[15:0], i_wstrb[1:0]);
            ADDR_CTRL: begin
               if (i_wstrb[0]) begin
                  ctrl_q.en    <= i_wdata[CTRL_EN];
                  ctrl_q.blink <= i_wdata[CTRL_BLINK];
               end
            end
            default: ;
         endcase
      end
   end

   // Bus response: one-cycle ack, read data only alongside a read ack.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ack   <= 1'b0;
         o_rdata <= '0;
      end else begin
         o_ack   <= i_req;
         o_rdata <= (i_req && !i_we) ? rd_mux : '0;
      end
   end

   // Blink counter advances on each rising scan-clock toggle and wraps.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bcnt_q  <= '0;
         blank_q <= 1'b0;
      end else begin
         if (scan_rise) bcnt_q <= bcnt_q + 1'b1;
         // EN=0 blanks regardless of BLINK.
         blank_q <= !ctrl_q.en || (ctrl_q.blink && phase);
      end
   end

   assign o_data     = data_q;
   assign o_scan_clk = scan_clk;
   assign o_blank    = blank_q;

endmodule

// File: tb/tb_seg7_mmio.sv
// -----------------------------------------------------------------------------
// tb_seg7_mmio
// Self-checking bench for seg7_mmio with DIV_DEFAULT=3 and BLINK_W=2.
// A behavioural model tracks registers, scan clock and blink state; read
// expectations are queued when a request is driven and popped at its ack.
// -----------------------------------------------------------------------------
module tb_seg7_mmio;
   import seg7_pkg::*;

   localparam logic [15:0] DIV_DEF = 16'd3;
   localparam int          BW      = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we  = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        ack;
   logic [31:0] rdata;
   logic [15:0] data;
   logic        scan_clk;
   logic        blank;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   seg7_mmio #(.DIV_DEFAULT(DIV_DEF), .BLINK_W(BW)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req      (req),
      .i_we       (we),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .i_wstrb    (wstrb),
      .o_ack      (ack),
      .o_rdata    (rdata),
      .o_data     (data),
      .o_scan_clk (scan_clk),
      .o_blank    (blank)
   );

   // ---------------- behavioural model ----------------
   logic [15:0]   m_data, m_div, m_left;
   logic [1:0]    m_ctrl;              // bit1 BLINK, bit0 EN
   logic          m_scan, m_blank;
   logic [BW-1:0] m_bcnt;

   always @(posedge clk) begin
      if (rst) begin
         m_data  <= '0;
         m_ctrl  <= 2'b01;
         m_div   <= DIV_DEF;
         m_left  <= DIV_DEF;
         m_scan  <= 1'b0;
         m_bcnt  <= '0;
         m_blank <= 1'b0;
      end else begin
         m_blank <= !m_ctrl[0] || (m_ctrl[1] && m_bcnt[BW-1]);
         if (req && we) begin
            if (addr == 2'd0) m_data <= merge16(m_data, wdata[15:0], wstrb[1:0]);
            if (addr == 2'd1 && wstrb[0]) m_ctrl <= wdata[1:0];
            if (addr == 2'd2) m_div <= merge16(m_div, wdata[15:0], wstrb[1:0]);
         end
         if (req && we && addr == 2'd2 && (|wstrb[1:0])) begin
            m_left <= merge16(m_div, wdata[15:0], wstrb[1:0]);
         end else if (m_left == 16'd0) begin
            m_scan <= !m_scan;
            m_left <= m_div;
            if (!m_scan) m_bcnt <= m_bcnt + 1'b1;
         end else begin
            m_left <= m_left - 16'd1;
         end
      end
   end

   function automatic logic [31:0] model_read(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: r[15:0] = m_data;
         2'd1: r[1:0]  = m_ctrl;
         2'd2: r[15:0] = m_div;
         default: begin
            r[0]      = m_bcnt[BW-1];
            r[1]      = m_scan;
            r[9:8]    = m_bcnt;
         end
      endcase
      return r;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: queue the expected response of any request being sampled,
   // then compare every output against the model just after the edge.
   task automatic tick();
      logic        had;
      logic [31:0] e;
      had = req && !rst;
      if (had) exp_q.push_back(we ? 32'h0 : model_read(addr));
      @(posedge clk);
      #1;
      check("ack", 32'(ack), 32'(had));
      if (had && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rdata", rdata, e);
      end else begin
         check("rdata_idle", rdata, 32'h0);
      end
      check("scan_clk", 32'(scan_clk), 32'(m_scan));
      check("o_data", 32'(data), 32'(m_data));
      check("o_blank", 32'(blank), 32'(m_blank));
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; wstrb = s;
      tick();
      req = 1'b0; we = 1'b0; wstrb = '0;
   endtask

   task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
      req = 1'b1; we = 1'b0; addr = a;
      tick();
      check(tag, rdata, exp);
      req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic s_w;
      int   ones;

      // Reset and default divider: toggles every 4 cycles.
      tick();
      tick();
      rst = 1'b0;
      check("rst_scan", 32'(scan_clk), 32'h0);
      check("rst_data", 32'(data), 32'h0);
      check("rst_blank", 32'(blank), 32'h0);
      check("rst_ack", 32'(ack), 32'h0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("div_default", 32'(scan_clk), 32'((k / 4) % 2));
      end

      // DATA write then back-to-back read.
      bus_write(ADDR_DATA, 32'h0000_ABCD, 4'b0011);
      check("data_abcd", 32'(data), 32'h0000_ABCD);
      bus_read("read_data", ADDR_DATA, 32'h0000_ABCD);

      // Partial strobe and ignored STATUS write.
      bus_write(ADDR_DATA, 32'h0000_1234, 4'b0001);
      check("data_ab34", 32'(data), 32'h0000_AB34);
      req = 1'b1; we = 1'b0; addr = ADDR_STATUS; tick();
      bus_write(ADDR_STATUS, 32'hFFFF_FFFF, 4'b1111);
      req = 1'b1; we = 1'b0; addr = ADDR_STATUS; tick();
      req = 1'b0;
      bus_read("data_after_status", ADDR_DATA, 32'h0000_AB34);

      // DIV=0: toggle every cycle.
      bus_write(ADDR_DIV, 32'h0, 4'b0011);
      s_w = m_scan;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("div0_toggle", 32'(scan_clk), 32'(s_w ^ k[0]));
      end

      // DIV=10, wait until count 2, then DIV=5: toggle 6 cycles later.
      bus_write(ADDR_DIV, 32'd10, 4'b0011);
      tick();
      tick();
      bus_write(ADDR_DIV, 32'd5, 4'b0011);
      s_w = m_scan;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("div5_toggle", 32'(scan_clk), 32'((k == 6) ? !s_w : s_w));
      end
      bus_read("read_div", ADDR_DIV, 32'd5);

      // Blink with DIV=0: blank high 4 of every 8 cycles.
      bus_write(ADDR_DIV, 32'h0, 4'b0011);
      bus_write(ADDR_CTRL, 32'h3, 4'b0001);
      tick();
      tick();
      ones = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (blank) ones++;
      end
      check("blink_duty", 32'(ones), 32'd8);
      for (int k = 0; k < 4; k++) begin
         req = 1'b1; we = 1'b0; addr = ADDR_STATUS; tick();
      end
      req = 1'b0;

      // EN only: blank low; then EN=0: blank one cycle after the write.
      bus_write(ADDR_CTRL, 32'h1, 4'b0001);
      tick();
      check("en_only_blank", 32'(blank), 32'h0);
      bus_write(ADDR_CTRL, 32'h0, 4'b0001);
      check("blank_delay", 32'(blank), 32'h0);
      tick();
      check("blank_en0", 32'(blank), 32'h1);

      // Reset during an access: no ack, everything back to defaults.
      rst = 1'b1; req = 1'b1; we = 1'b0; addr = ADDR_DATA;
      tick();
      check("rst_mid_ack", 32'(ack), 32'h0);
      rst = 1'b0; req = 1'b0;
      check("rst2_data", 32'(data), 32'h0);
      check("rst2_blank", 32'(blank), 32'h0);
      check("rst2_scan", 32'(scan_clk), 32'h0);
      bus_read("rst2_ctrl", ADDR_CTRL, 32'h1);
      bus_read("rst2_div", ADDR_DIV, 32'(DIV_DEF));
      bus_read("rst2_dreg", ADDR_DATA, 32'h0);
      for (int k = 0; k < 10; k++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
